segway_drive_math: RTL and testbench

SEGWAY_DRIVE_MATH -- requirements
Module: segway_drive_math

---
 rtl/segway_pkg.sv | 18 +
 rtl/torque_shape.sv | 42 ++++
 rtl/segway_drive_math.sv | 201 ++++++++++++++++++++
 tb/tb_segway_drive_math.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared constants for the segway drive math datapath: torque shaping and steering.
package segway_pkg;

  // Torque shaping: below LOW_BAND the command is amplified, above it a minimum duty is added
  localparam int LOW_BAND  = 'h3C;
  localparam int MIN_DUTY  = 'h3C0;
  localparam int GAIN_MULT = 4;

  // Steering pot clip window and mid-scale centre, expressed for a 12-bit pot
  localparam int CLIP_LO      = 'h200;
  localparam int CLIP_HI      = 'hE00;
  localparam int STEER_CENTRE = 'h7FF;

  // Steering scale of 3/16 implemented as multiply then arithmetic shift
  localparam int STEER_MUL   = 3;
  localparam int STEER_SHIFT = 4;

endpackage

// File: rtl/torque_shape.sv
// Per-side torque shaping followed by saturation to the W-bit signed motor command range.
module torque_shape
  import segway_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W+1:0] t,
  output logic signed [W-1:0] spd
);

  localparam int XW = W + 5;
  localparam logic signed [XW-1:0] LB     = XW'(LOW_BAND);
  localparam logic signed [XW-1:0] DUTY   = XW'(MIN_DUTY);
  localparam logic signed [XW-1:0] GAIN   = XW'(GAIN_MULT);
  localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = XW'(-(1 << (W - 1)));

  logic signed [XW-1:0] tx;
  logic signed [XW-1:0] mag;
  logic signed [XW-1:0] shaped;
  logic signed [XW-1:0] sat;

  // Small commands get gain, larger ones get a minimum-duty offset in their own direction, then clamp
  always_comb begin
    tx  = {{(XW - W - 2){t[W+1]}}, t};
    mag = tx[XW-1] ? -tx : tx;
    if (mag > LB) begin
      shaped = tx[XW-1] ? (tx - DUTY) : (tx + DUTY);
    end else begin
      shaped = tx * GAIN;
    end
    if (shaped > SAT_HI) begin
      sat = SAT_HI;
    end else if (shaped < SAT_LO) begin
      sat = SAT_LO;
    end else begin
      sat = shaped;
    end
    spd = W'(sat);
  end

endmodule

// File: rtl/segway_drive_math.sv
// Segway drive math: soft-start scaling of the PID term, steering mix, torque shaping and overspeed flag.
module segway_drive_math
  import segway_pkg::*;
#(
  parameter int W        = 12,
  parameter int SS_W     = 8,
  parameter int SS_PRE   = 4,
  parameter int FAST_HI  = 1536,
  parameter int FAST_LO  = 1280,
  parameter int FAST_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic        [W-1:0] steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                out_vld,
  output logic                too_fast
);

  localparam int SC = W - 12;
  localparam int CW = $clog2(FAST_CNT + 1);
  localparam logic        [W-1:0]  CLIP_LO_S = W'(CLIP_LO << SC);
  localparam logic        [W-1:0]  CLIP_HI_S = W'(CLIP_HI << SC);
  localparam logic signed [W+3:0]  CENTRE_S  = (W + 4)'(((STEER_CENTRE + 1) << SC) - 1);
  localparam logic signed [W+3:0]  MUL_S     = (W + 4)'(STEER_MUL);
  localparam logic        [W-1:0]  HI_U      = W'(FAST_HI);
  localparam logic        [W-1:0]  LO_U      = W'(FAST_LO);
  localparam logic        [CW-1:0] CNT_LAST  = CW'(FAST_CNT - 1);

  logic [1:0]              rst_sync;
  logic                    rst_i_n;
  logic [SS_PRE-1:0]       pre;
  logic [SS_W-1:0]         ss;

  logic signed [W+SS_W:0]  prod;
  logic [W-1:0]            clip;
  logic signed [W+3:0]     diff;
  logic signed [W+3:0]     scaled;
  logic signed [W-1:0]     pid_ss_d;
  logic signed [W-1:0]     steer_d;

  logic                    v1;
  logic                    v2;
  logic                    v3;
  logic signed [W-1:0]     pid_ss1;
  logic signed [W-1:0]     steer1;
  logic                    en1;

  logic signed [W+1:0]     pid_x;
  logic signed [W+1:0]     steer_x;
  logic signed [W+1:0]     lft_d;
  logic signed [W+1:0]     rght_d;
  logic signed [W+1:0]     lft2;
  logic signed [W+1:0]     rght2;

  logic signed [W-1:0]     lft_shaped;
  logic signed [W-1:0]     rght_shaped;
  logic        [W-1:0]     lft_mag;
  logic        [W-1:0]     rght_mag;
  logic                    qual;
  logic [CW-1:0]           cnt;

  assign out_vld = v3;
  assign rst_i_n = rst_sync[1];

  // Reset asserts immediately but is released only after two clean clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  // Soft-start ramp: one ss step per prescaler wrap, held at all-ones, cleared while unpowered
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      pre <= '0;
      ss  <= '0;
    end else if (!pwr_up) begin
      pre <= '0;
      ss  <= '0;
    end else begin
      pre <= pre + 1'b1;
      if ((&pre) && !(&ss)) begin
        ss <= ss + 1'b1;
      end
    end
  end

  // Stage 1 arithmetic: soft-start scaled PID and clipped, centred, 3/16-scaled steering term
  always_comb begin
    prod     = PID_cntrl * $signed({1'b0, ss});
    pid_ss_d = W'(prod >>> SS_W);
    if (steer_pot < CLIP_LO_S) begin
      clip = CLIP_LO_S;
    end else if (steer_pot > CLIP_HI_S) begin
      clip = CLIP_HI_S;
    end else begin
      clip = steer_pot;
    end
    diff    = $signed({4'b0000, clip}) - CENTRE_S;
    scaled  = diff * MUL_S;
    steer_d = W'(scaled >>> STEER_SHIFT);
  end

  // Stage 2 arithmetic: mix steering into each side with two bits of headroom
  always_comb begin
    pid_x   = {{2{pid_ss1[W-1]}}, pid_ss1};
    steer_x = {{2{steer1[W-1]}}, steer1};
    if (en1) begin
      lft_d  = pid_x + steer_x;
      rght_d = pid_x - steer_x;
    end else begin
      lft_d  = pid_x;
      rght_d = pid_x;
    end
  end

  // Pipeline valids and data; losing power drops every in-flight sample
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      pid_ss1 <= '0;
      steer1  <= '0;
      en1     <= 1'b0;
      lft2    <= '0;
      rght2   <= '0;
    end else begin
      v1 <= pwr_up & in_vld;
      v2 <= pwr_up & v1;
      v3 <= pwr_up & v2;
      if (in_vld) begin
        pid_ss1 <= pid_ss_d;
        steer1  <= steer_d;
        en1     <= en_steer;
      end
      if (v1) begin
        lft2  <= lft_d;
        rght2 <= rght_d;
      end
    end
  end

  torque_shape #(.W(W)) u_lft (
    .t   (lft2),
    .spd (lft_shaped)
  );

  torque_shape #(.W(W)) u_rght (
    .t   (rght2),
    .spd (rght_shaped)
  );

  // Decide whether the sample entering the output register advances the overspeed persistence count
  always_comb begin
    lft_mag  = lft_shaped[W-1] ? (~lft_shaped + 1'b1) : lft_shaped;
    rght_mag = rght_shaped[W-1] ? (~rght_shaped + 1'b1) : rght_shaped;
    if (too_fast) begin
      qual = (lft_mag <= LO_U) && (rght_mag <= LO_U);
    end else begin
      qual = (lft_mag > HI_U) || (rght_mag > HI_U);
    end
  end

  // Output stage: motor commands and overspeed flag move together with each new output sample
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      too_fast <= 1'b0;
      cnt      <= '0;
    end else if (!pwr_up) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      too_fast <= 1'b0;
      cnt      <= '0;
    end else if (v2) begin
      lft_spd  <= lft_shaped;
      rght_spd <= rght_shaped;
      if (qual) begin
        if (cnt == CNT_LAST) begin
          too_fast <= ~too_fast;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_segway_drive_math.sv
// Scoreboard bench for segway_drive_math: arithmetic reference model plus directed corner cases.
module tb_segway_drive_math;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_vld;
  logic signed [W-1:0] PID_cntrl;
  logic        [W-1:0] steer_pot;
  logic                en_steer;
  logic                pwr_up;
  logic signed [W-1:0] lft_spd;
  logic signed [W-1:0] rght_spd;
  logic                out_vld;
  logic                too_fast;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   ss_clks   = 0;
  int   tf_m      = 0;
  int   run_m     = 0;
  bit   ramp_mode = 1'b0;
  int   last_lft  = 0;

  segway_drive_math dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .PID_cntrl (PID_cntrl),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .out_vld   (out_vld),
    .too_fast  (too_fast)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int shape(input int t);
    int r;
    if (t > 60) r = t + 960;
    else if (t < -60) r = t - 960;
    else r = t * 4;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return r;
  endfunction

  task automatic check_output(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic signed [W-1:0] pid, input logic [W-1:0] pot, input logic en);
    in_vld    = 1'b1;
    PID_cntrl = pid;
    steer_pot = pot;
    en_steer  = en;
    tick(1);
    in_vld = 1'b0;
  endtask

  // Reference model: each accepted sample predicts its outputs from the current soft-start level
  always @(posedge clk) begin
    int   ss;
    int   pid_ss;
    int   pot;
    int   s;
    int   l;
    int   r;
    exp_t e;
    if (!rst_n || !pwr_up) begin
      exp_q.delete();
      ss_clks = 0;
      tf_m    = 0;
      run_m   = 0;
    end else begin
      if (in_vld) begin
        ss = ss_clks / 16;
        if (ss > 255) ss = 255;
        pid_ss = floor_div(int'(PID_cntrl) * ss, 256);
        pot = int'(steer_pot);
        if (pot < 'h200) pot = 'h200;
        if (pot > 'hE00) pot = 'hE00;
        s = floor_div((pot - 'h7FF) * 3, 16);
        l = en_steer ? pid_ss + s : pid_ss;
        r = en_steer ? pid_ss - s : pid_ss;
        e.l = shape(l);
        e.r = shape(r);
        exp_q.push_back(e);
      end
      ss_clks++;
    end
  end

  // Monitor: every presented output sample is matched against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    bit   q;
    if (out_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out_vld actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        if (tf_m != 0) q = (iabs(e.l) <= 1280) && (iabs(e.r) <= 1280);
        else q = (iabs(e.l) > 1536) || (iabs(e.r) > 1536);
        if (q) begin
          run_m++;
          if (run_m == 4) begin
            tf_m  = (tf_m != 0) ? 0 : 1;
            run_m = 0;
          end
        end else begin
          run_m = 0;
        end
        check_output("lft_spd", int'(lft_spd), e.l);
        check_output("rght_spd", int'(rght_spd), e.r);
        check_output("too_fast", int'(too_fast), tf_m);
        if (ramp_mode) begin
          check_output("ramp_monotonic", int'(int'(lft_spd) >= last_lft), 1);
          last_lft = int'(lft_spd);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    pwr_up    = 1'b0;
    in_vld    = 1'b0;
    PID_cntrl = '0;
    steer_pot = '0;
    en_steer  = 1'b0;

    tick(3);
    check_output("reset_lft", int'(lft_spd), 0);
    check_output("reset_rght", int'(rght_spd), 0);
    check_output("reset_out_vld", int'(out_vld), 0);
    check_output("reset_too_fast", int'(too_fast), 0);
    rst_n = 1'b1;
    tick(4);
    pwr_up = 1'b1;
    tick(4100);

    $display("[TB] full-scale PID, no steering, latency");
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    tick(1);
    check_output("latency_early", int'(out_vld), 0);
    tick(1);
    check_output("latency_out_vld", int'(out_vld), 1);
    check_output("full_pid_lft", int'(lft_spd), 1979);
    check_output("full_pid_rght", int'(rght_spd), 1979);

    $display("[TB] steering extremes and centre");
    apply_stimulus(12'sd0, 12'hFFF, 1'b1);
    tick(2);
    check_output("steer_max_lft", int'(lft_spd), 1248);
    check_output("steer_max_rght", int'(rght_spd), -1248);
    apply_stimulus(12'sd0, 12'h7FF, 1'b1);
    tick(2);
    check_output("steer_centre_lft", int'(lft_spd), 0);
    check_output("steer_centre_rght", int'(rght_spd), 0);

    $display("[TB] low band and min duty edges");
    apply_stimulus(12'sd21, 12'h7FF, 1'b0);
    tick(2);
    check_output("band_gain_lft", int'(lft_spd), 80);
    apply_stimulus(-12'sd61, 12'h7FF, 1'b0);
    tick(2);
    check_output("band_duty_lft", int'(lft_spd), -1021);
    check_output("band_duty_rght", int'(rght_spd), -1021);

    $display("[TB] overspeed persistence, back-to-back samples");
    repeat (4) apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    repeat (2) apply_stimulus(12'sd62, 12'h7FF, 1'b0);
    apply_stimulus(12'sd442, 12'h7FF, 1'b0);
    repeat (4) apply_stimulus(12'sd62, 12'h7FF, 1'b0);
    tick(3);
    check_output("too_fast_released", int'(too_fast), 0);

    $display("[TB] random samples");
    for (int i = 0; i < 300; i++) begin
      in_vld    = ($urandom_range(0, 9) < 7);
      PID_cntrl = W'($urandom_range(0, 4095));
      steer_pot = W'($urandom_range(0, 4095));
      en_steer  = 1'($urandom_range(0, 1));
      tick(1);
    end
    in_vld = 1'b0;
    tick(4);

    $display("[TB] power drop then soft-start ramp");
    repeat (4) apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    tick(2);
    check_output("too_fast_set", int'(too_fast), 1);
    in_vld = 1'b1;
    pwr_up = 1'b0;
    tick(1);
    check_output("pwr_drop_lft", int'(lft_spd), 0);
    check_output("pwr_drop_rght", int'(rght_spd), 0);
    check_output("pwr_drop_too_fast", int'(too_fast), 0);
    check_output("pwr_drop_out_vld", int'(out_vld), 0);
    pwr_up    = 1'b1;
    ramp_mode = 1'b1;
    last_lft  = 0;
    tick(1);
    check_output("ramp_start_lft", int'(lft_spd), 0);
    tick(4200);
    in_vld = 1'b0;
    tick(4);
    ramp_mode = 1'b0;
    check_output("ramp_final_lft", int'(lft_spd), 1979);

    $display("[TB] reset with samples in flight");
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    rst_n  = 1'b0;
    pwr_up = 1'b0;
    #1;
    check_output("mid_reset_lft", int'(lft_spd), 0);
    check_output("mid_reset_rght", int'(rght_spd), 0);
    check_output("mid_reset_out_vld", int'(out_vld), 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    pwr_up = 1'b1;
    tick(300);

    $display("[TB] single-clock power drop with samples in flight");
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    tick(2);
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    apply_stimulus(12'sh3FF, 12'h7FF, 1'b0);
    pwr_up = 1'b0;
    tick(1);
    check_output("pulse_drop_lft", int'(lft_spd), 0);
    check_output("pulse_drop_out_vld", int'(out_vld), 0);
    pwr_up = 1'b1;
    tick(6);
    check_output("pulse_hold_lft", int'(lft_spd), 0);
    check_output("pulse_hold_rght", int'(rght_spd), 0);

    tick(5);
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
